// File: rtl/patterns_pkg.sv
// ----------------------------------------------------------------------------
// patterns_pkg
// Shared types and widths for the Patterns datapath control blocks.
//   seq_state_e : frame sequencer state encoding (IDLE=0, ACTIVE=1,
//                 HBLANK=2, VBLANK=3)
//   LINE_W      : width of the line index
//   FRAME_W     : width of the completed-frame counter
//   TIMER_W     : width of the blanking interval timer
// ----------------------------------------------------------------------------
package patterns_pkg;

    localparam int LINE_W  = 12;
    localparam int FRAME_W = 8;
    localparam int TIMER_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } seq_state_e;

    // Index of the final active line for a frame of the given height.
    function automatic logic [LINE_W-1:0] last_line_idx(input int lines);
        return LINE_W'(lines - 1);
    endfunction

endpackage

// File: rtl/blank_timer.sv
// ----------------------------------------------------------------------------
// blank_timer
// Loadable down-counter timing the horizontal and vertical blanking intervals.
// Loading N makes done assert on the Nth cycle after the load edge, so a
// state that leaves on done lasts exactly N cycles.
//   clk   in   clock
//   rst_n in   asynchronous active-low reset
//   load  in   load value into the counter (has priority over counting)
//   value in   interval length in cycles, 1..4095
//   done  out  high during the final cycle of the interval
// ----------------------------------------------------------------------------
module blank_timer
    import patterns_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    output logic               done
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            // Saturate at zero so the counter rests quietly between intervals.
            count_d = count_q - TIMER_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == TIMER_W'(1));

endmodule

// File: rtl/frame_sequencer.sv
// ----------------------------------------------------------------------------
// frame_sequencer
// Line/frame sequencer sitting after the pixel counter. Enables the counter
// for each active line, inserts horizontal blanking after every line and
// vertical blanking after the last line, and emits sync / frame strobes.
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   start     in   begin frame generation (honoured only in IDLE)
//   stop      in   halt at the next frame boundary
//   test      in   1 = TEST_LINES per frame, 0 = LINES_PER_FRAME
//   end_line  in   end-of-line from the pixel counter (used only in ACTIVE)
//   pix_enb   out  pixel counter enable, high in ACTIVE
//   hsync     out  high during HBLANK
//   vsync     out  high during VBLANK
//   end_frame out  one-cycle pulse in the first VBLANK cycle
//   line_cnt  out  active line index within the frame
//   frame_cnt out  completed-frame count, wraps
//   busy      out  high in every state except IDLE
// All outputs are registered.
// ----------------------------------------------------------------------------
module frame_sequencer
    import patterns_pkg::*;
#(
    parameter int LINES_PER_FRAME = 1024,
    parameter int TEST_LINES      = 4,
    parameter int HBLANK_CYC      = 16,
    parameter int VBLANK_CYC      = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               test,
    input  logic               end_line,
    output logic               pix_enb,
    output logic               hsync,
    output logic               vsync,
    output logic               end_frame,
    output logic [LINE_W-1:0]  line_cnt,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               busy
);

    localparam logic [LINE_W-1:0]  LAST_NORMAL = last_line_idx(LINES_PER_FRAME);
    localparam logic [LINE_W-1:0]  LAST_TEST   = last_line_idx(TEST_LINES);
    localparam logic [TIMER_W-1:0] HBLANK_LEN  = TIMER_W'(HBLANK_CYC);
    localparam logic [TIMER_W-1:0] VBLANK_LEN  = TIMER_W'(VBLANK_CYC);

    seq_state_e         state_q, state_d;
    logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               test_q, test_d;
    logic               stop_pend_q, stop_pend_d;
    logic               pix_enb_q, pix_enb_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               end_frame_q, end_frame_d;
    logic               busy_q, busy_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_done;
    logic [LINE_W-1:0]  last_line;

    blank_timer u_blank_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .value (timer_value),
        .done  (timer_done)
    );

    // Frame height is fixed by the test_q snapshot taken at frame start.
    assign last_line = test_q ? LAST_TEST : LAST_NORMAL;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        frame_cnt_d = frame_cnt_q;
        test_d      = test_q;
        // A stop seen anywhere in a running frame is held until the boundary.
        stop_pend_d = stop_pend_q | (stop & (state_q != ST_IDLE));
        timer_load  = 1'b0;
        timer_value = '0;
        end_frame_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    test_d     = test;
                    line_cnt_d = '0;
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (end_line) begin
                    timer_load  = 1'b1;
                    timer_value = HBLANK_LEN;
                    state_d     = ST_HBLANK;
                end
            end
            ST_HBLANK: begin
                if (timer_done) begin
                    if (line_cnt_q == last_line) begin
                        timer_load  = 1'b1;
                        timer_value = VBLANK_LEN;
                        end_frame_d = 1'b1;
                        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                        state_d     = ST_VBLANK;
                    end else begin
                        line_cnt_d = line_cnt_q + LINE_W'(1);
                        state_d    = ST_ACTIVE;
                    end
                end
            end
            ST_VBLANK: begin
                if (timer_done) begin
                    if (stop_pend_d) begin
                        stop_pend_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        line_cnt_d = '0;
                        test_d     = test;
                        state_d    = ST_ACTIVE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so they
        // line up with the state register.
        pix_enb_d = (state_d == ST_ACTIVE);
        hsync_d   = (state_d == ST_HBLANK);
        vsync_d   = (state_d == ST_VBLANK);
        busy_d    = (state_d != ST_IDLE);
    end

    // NOTE: every flop, outputs included, is cleared by the asynchronous
    // reset, so a mid-frame reset leaves no strobe or count behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            test_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            pix_enb_q   <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            end_frame_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            test_q      <= test_d;
            stop_pend_q <= stop_pend_d;
            pix_enb_q   <= pix_enb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            end_frame_q <= end_frame_d;
            busy_q      <= busy_d;
        end
    end

    assign pix_enb   = pix_enb_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign end_frame = end_frame_q;
    assign line_cnt  = line_cnt_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_frame_sequencer
// Directed bench for frame_sequencer with 4 normal lines, 2 test lines,
// 3-cycle HBLANK and 5-cycle VBLANK. Inputs change and outputs are sampled
// on the falling edge; the design acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_frame_sequencer;

    localparam int LPF = 4;
    localparam int TL  = 2;
    localparam int HB  = 3;
    localparam int VB  = 5;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        test;
    logic        end_line;
    logic        pix_enb;
    logic        hsync;
    logic        vsync;
    logic        end_frame;
    logic [11:0] line_cnt;
    logic [7:0]  frame_cnt;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    frame_sequencer #(
        .LINES_PER_FRAME (LPF),
        .TEST_LINES      (TL),
        .HBLANK_CYC      (HB),
        .VBLANK_CYC      (VB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .test      (test),
        .end_line  (end_line),
        .pix_enb   (pix_enb),
        .hsync     (hsync),
        .vsync     (vsync),
        .end_frame (end_frame),
        .line_cnt  (line_cnt),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    // 60 ns clock
    initial clk = 1'b0;
    always #30 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pix_enb"},   pix_enb,   0);
        check({tag, ".hsync"},     hsync,     0);
        check({tag, ".vsync"},     vsync,     0);
        check({tag, ".end_frame"}, end_frame, 0);
        check({tag, ".line_cnt"},  line_cnt,  0);
        check({tag, ".frame_cnt"}, frame_cnt, 0);
        check({tag, ".busy"},      busy,      0);
    endtask

    // Entered in the first ACTIVE cycle of line ln; returns in the first
    // cycle after HBLANK. end_line rises in the 10th pix_enb cycle.
    task automatic run_line(input int ln, input bit noise, input bit pulse_stop, input bit set_test);
        int n;
        int act;
        check("line_cnt", line_cnt, ln);
        check("pix_enb_line", pix_enb, 1);
        act = 1;
        for (int i = 0; i < 9; i++) begin
            if (i == 2 && pulse_stop) stop = 1'b1;
            if (i == 3 && set_test)   test = 1'b1;
            step();
            stop = 1'b0;
            act += int'(pix_enb);
        end
        check("active_len", act, 10);
        end_line = 1'b1;
        step();
        end_line = 1'b0;
        check("hsync_on", hsync, 1);
        check("pix_enb_off", pix_enb, 0);
        n = 0;
        while (hsync && n < 40) begin
            if (noise) end_line = (n == 1);
            n++;
            step();
        end
        end_line = 1'b0;
        check("hsync_len", n, HB);
    endtask

    task automatic run_frame(input int nl, input int frame_exp, input bit exp_idle,
                             input bit noise, input int test_at, input int stop_at);
        int n;
        int ef;
        for (int l = 0; l < nl; l++) begin
            run_line(l, noise, l == stop_at, l == test_at);
        end
        check("end_frame_on", end_frame, 1);
        check("vsync_on", vsync, 1);
        check("frame_cnt", frame_cnt, frame_exp);
        check("line_cnt_vb", line_cnt, nl - 1);
        n  = 0;
        ef = 0;
        while (vsync && n < 80) begin
            if (noise) end_line = (n == 1);
            ef += int'(end_frame);
            n++;
            step();
        end
        end_line = 1'b0;
        check("vsync_len", n, VB);
        check("end_frame_pulses", ef, 1);
        if (exp_idle) begin
            check("busy_idle", busy, 0);
            check("pix_enb_idle", pix_enb, 0);
        end else begin
            check("pix_enb_next", pix_enb, 1);
            check("line_cnt_next", line_cnt, 0);
            check("busy_next", busy, 1);
        end
    endtask

    // Holds end_line high so each line is one ACTIVE cycle; returns in the
    // cycle where the target-th end_frame pulse is visible.
    task automatic run_frames(input int target);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        end_line = 1'b1;
        while (seen < target && cyc < target * 80 + 100) begin
            step();
            cyc++;
            if (end_frame) seen++;
        end
        check("frames_reached", seen, target);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        test     = 1'b0;
        end_line = 1'b0;
        repeat (2) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // 1: normal frame of 4 lines
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_pix_enb", pix_enb, 1);
        check("start_busy", busy, 1);
        run_frame(LPF, 1, 0, 0, -1, -1);

        // 2 + 5: test raised mid-frame (frame stays 4 lines), spurious end_line in blanking
        run_frame(LPF, 2, 0, 1, 1, -1);

        // 2 + 3: next frame is 2 lines; stop during line 1 lets it finish
        run_frame(TL, 3, 1, 0, -1, 1);
        step();
        check("stay_idle_busy", busy, 0);
        check("stay_idle_frame_cnt", frame_cnt, 3);

        // 4: start with stop in IDLE is ignored
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_busy", busy, 0);
        check("start_stop_pix_enb", pix_enb, 0);
        step();
        check("start_stop_busy2", busy, 0);

        test  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_busy", busy, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy_line_cnt", line_cnt, 0);
        check("start_busy_pix_enb", pix_enb, 1);
        run_frame(LPF, 4, 0, 1, -1, -1);

        // 6: run up to frame 255 (later frames in test mode), reset inside VBLANK
        test = 1'b1;
        run_frames(251);
        check("fc255", frame_cnt, 255);
        check("fc255_vsync", vsync, 1);
        @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) step();
        check_all_zero("held_reset");
        end_line = 1'b0;
        rst_n    = 1'b1;
        step();
        check("post_reset_busy", busy, 0);

        // Wrap run: 256 frames from reset
        start = 1'b1;
        step();
        start = 1'b0;
        run_frames(255);
        check("wrap_pre", frame_cnt, 255);
        run_frames(1);
        check("wrap_zero", frame_cnt, 0);
        check("wrap_vsync", vsync, 1);
        end_line = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check("final_idle", busy, 0);
        check("final_frame_cnt", frame_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Line/frame sequencer for the Patterns datapath, directly downstream of the 12-bit pixel counter. It drives the counter's enable and consumes its end-of-line pulse. It counts lines, inserts horizontal and vertical blanking intervals, and emits sync and frame-boundary strobes to the pattern generators. Normal and test frame heights are selected by `test`, consistent with the counter's normal and test line lengths.

## Interface
Parameters:
- `LINES_PER_FRAME`, 1024: active lines per frame in normal mode; range 1..4096.
- `TEST_LINES`, 4: active lines per frame in test mode; range 1..4096.
- `HBLANK_CYC`, 16: cycles of horizontal blanking after each line; minimum 1.
- `VBLANK_CYC`, 64: cycles of vertical blanking after the last line's HBLANK; minimum 1.

Ports:
- `clk`  in  1  master clock, 60 ns.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  pulse; begins frame generation when in IDLE.
- `stop`  in  1  pulse; requests a halt at the next frame boundary.
- `test`  in  1  1 selects `TEST_LINES`, 0 selects `LINES_PER_FRAME`.
- `end_line`  in  1  end-of-line indication from the pixel counter.
- `pix_enb`  out  1  enable to the pixel counter; high only in ACTIVE.
- `hsync`  out  1  high during HBLANK.
- `vsync`  out  1  high during VBLANK.
- `end_frame`  out  1  one-cycle pulse on entry to VBLANK.
- `line_cnt`  out  12  current active line index, starting at 0.
- `frame_cnt`  out  8  completed-frame count; wraps 255 -> 0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- All outputs are registered. Reset value of every output is 0; the state machine resets to IDLE.
- **IDLE**
  - On `start` (and no `stop` in the same cycle), latch `test` into `test_q`, clear `line_cnt`, and go to ACTIVE.
- **ACTIVE**
  - `pix_enb` = 1.
  - `end_line` = 1 -> go to HBLANK and load the blank timer with `HBLANK_CYC`.
- **HBLANK**
  - `hsync` = 1.
  - When the timer expires:
    - If `line_cnt` == last, go to VBLANK, load `VBLANK_CYC`, and pulse `end_frame`.
    - Otherwise increment `line_cnt` and go to ACTIVE.
  - last = `test_q` ? `TEST_LINES`-1 : `LINES_PER_FRAME`-1.
- **VBLANK**
  - `vsync` = 1.
  - `frame_cnt` increments on entry.
  - When the timer expires:
    - If a stop is pending, go to IDLE and clear the pending flag.
    - Otherwise clear `line_cnt`, re-latch `test` into `test_q`, and go to ACTIVE.
- `stop` is latched as a pending flag in any non-IDLE state. It never truncates a frame.
- Boundary conditions:
  - `start` while `busy` is ignored.
  - `start` and `stop` in the same IDLE cycle: `stop` wins and the block stays in IDLE.
  - `end_line` outside ACTIVE is ignored.
  - `test` changes mid-frame take effect only at the next frame start.
  - `rst_n` asserted mid-frame forces IDLE and zero outputs immediately (asynchronous). No partial-frame strobes follow.

## Timing
- `start` sampled at edge N -> `pix_enb`=1 and `busy`=1 from edge N+1.
- `end_line` sampled high at edge M -> at edge M+1, `pix_enb`=0 and `hsync`=1.
  - The pixel counter may advance once on edge M; it clears while `pix_enb` is low.
- `hsync` stays high for exactly `HBLANK_CYC` cycles.
- `vsync` stays high for exactly `VBLANK_CYC` cycles and follows the last HBLANK with no gap.
- `end_frame` coincides with the first `vsync` cycle.
- ACTIVE follows blanking with no idle cycle.
- `line_cnt` updates on the same edge that `pix_enb` rises.

## Structure
- Shared package/include `patterns_pkg`:
  - state encoding (IDLE=0, ACTIVE=1, HBLANK=2, VBLANK=3);
  - `LINE_W`=12;
  - `FRAME_W`=8.
- Sub-module `blank_timer`: a loadable down-counter with `load`, `value[11:0]` and a `done` output, used for both the HBLANK and VBLANK intervals.

## Test plan
Bench parameters: `LINES_PER_FRAME`=4, `TEST_LINES`=2, `HBLANK_CYC`=3, `VBLANK_CYC`=5.
1. Reset, then `start` with `test`=0, and `end_line` pulsed after 10 `pix_enb` cycles per line.
   - Expect 4 ACTIVE periods with `line_cnt` 0..3, each followed by 3-cycle `hsync`.
   - Then `end_frame` pulse, 5-cycle `vsync`, `frame_cnt`=1, and ACTIVE again at `line_cnt`=0.
2. Set `test`=1 mid-frame.
   - Current frame completes 4 lines; next frame has 2 lines (`line_cnt` 0..1).
3. `stop` pulsed during line 1.
   - Frame finishes all lines and VBLANK, then IDLE with `busy`=0 and `pix_enb`=0.
4. `start` and `stop` asserted together in IDLE -> remains IDLE.
   - `start` asserted while ACTIVE -> no effect on `line_cnt`.
5. `end_line` pulsed during HBLANK and VBLANK -> ignored; interval lengths unchanged.
6. `rst_n` dropped during VBLANK of frame 255.
   - Expect all outputs 0 asynchronously.
   - A separate 256-frame run shows `frame_cnt` wrapping 255 -> 0.
